obuf_arb: RTL and testbench
===========================

# obuf_arb

Output-port stage of the mesh router, one instance per output direction, directly downstream of the per-input IBUFs. It collects the per-direction request bit from each IBUF and selects one requester per cycle by round-robin. The granted payload is pushed into a small output FIFO. The FIFO drains to the next router or local sink over a valid/ready handshake. The block drives the `arb_gnt` and `obuf_rdy` bits that IBUFs use to clear their pending request (`clr = arb_gnt & obuf_rdy`).

## Interface
Parameters:
- `PYLD_W`, default `` `PKT_W ``: payload width.
- `N_IN`, default 7: number of requesting inputs, one per direction N/S/E/W/B/Q/R, indexed by the `DIR_*` macros.
- `DEPTH`, default 2: output FIFO entries; legal range ≥1.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `arb_req`  in  N_IN  bit i = IBUF i requests this output; held until granted.
- `payload_i`  in  N_IN*PYLD_W  IBUF payloads concatenated; input i occupies bits [i*PYLD_W +: PYLD_W].
- `arb_gnt`  out  N_IN  one-hot grant, combinational; all zero when `arb_req` is zero.
- `obuf_rdy`  out  1  FIFO can accept; broadcast to all IBUFs.
- `out_vld`  out  1  head entry valid.
- `out_rdy`  in  1  downstream accepts.
- `payload_o`  out  PYLD_W  head entry data.

## Operation
- **Grant.** Combinational search of `arb_req`.
  - Start at pointer `ptr`, ascending index, wrapping from N_IN-1 to 0.
  - The first set bit is granted.
- **Transfer (push).** Occurs at a rising edge where `|arb_req && obuf_rdy`.
  - Writes the granted input's payload at the FIFO tail.
  - Updates `ptr` to granted index + 1, wrapping at N_IN.
- **No transfer.** `ptr` holds.
  - `arb_gnt` may still be non-zero while `obuf_rdy`=0; IBUFs then see `clr`=0 and keep their request.
- **obuf_rdy.** `count != DEPTH`.
  - Depends only on registered state; it never looks at `out_rdy`, so there is no ready pass-through path.
- **Pop.** `out_vld && out_rdy` at a rising edge advances the head.
- **Simultaneous push and pop.** Allowed whenever `count` < DEPTH.
  - `count` is unchanged; FIFO order is preserved.
- **Full FIFO.** A pop when `count` == DEPTH raises `obuf_rdy` next cycle; no same-cycle push.
- **Width rules.**
  - `count` is `$clog2(DEPTH+1)` bits.
  - Read and write pointers are `$clog2(DEPTH)` bits (minimum 1) and wrap at DEPTH; non-power-of-2 DEPTH wraps explicitly.
  - `ptr` is `$clog2(N_IN)` bits and wraps at N_IN.
- **Reset** (asynchronous, any time, including mid-transfer):
  - `count`=0, `ptr`=0, all FIFO entries=0.
  - Outputs: `out_vld`=0, `obuf_rdy`=1, `payload_o`=0, `arb_gnt`=0 (given `arb_req`=0).
  - FIFO contents are discarded. IBUFs are reset on the same event.

## Timing
- `arb_gnt` is valid in the same cycle `arb_req` is seen.
- IBUF drops its request one cycle after the transfer edge, so no input is granted twice for one packet.
- Latency from transfer edge to `out_vld`=1 with the payload on `payload_o` (FIFO previously empty): 1 cycle.
- Sustained throughput: 1 packet/cycle when `out_rdy`=1 and DEPTH≥2; DEPTH=1 gives 1 packet per 2 cycles.
- `payload_o` and `out_vld` are driven from registers; `arb_gnt` is the only combinational output.

## Configuration
- `OBUF_FIXED_PRIO_EN` defined:
  - `ptr` is removed.
  - Grant is fixed priority: lowest set index wins (N highest).
  - Intended for deterministic debug.
- `OBUF_FIXED_PRIO_EN` undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- **Reset.** Assert `rst` for 2 cycles, then deassert → `out_vld`=0, `obuf_rdy`=1, `arb_gnt`=0, `payload_o`=0.
- **Single request.** `arb_req`=7'b0001000, payload 3 = 0xA5, `out_rdy`=1 → `arb_gnt`=7'b0001000 same cycle; next cycle `out_vld`=1, `payload_o`=0xA5; then `out_vld`=0.
- **Fairness.** All 7 requests held continuously, each re-asserted after its grant, `out_rdy`=1 → grant order 0,1,2,3,4,5,6,0. With `OBUF_FIXED_PRIO_EN` the grant is 0 every cycle.
- **Backpressure.** `out_rdy`=0 with requests on inputs 1 and 2 → two pushes, then `obuf_rdy`=0 and no further push while `arb_gnt` stays non-zero. Pulse `out_rdy`=1 for one cycle → input 1's payload pops first; `obuf_rdy`=1 the following cycle.
- **Simultaneous push/pop.** `count`=1, push plus pop in the same cycle → `count` stays 1 and data exits in push order.
- **Reset mid-operation.** `rst` pulsed with `count`=2 and `ptr`=5 → immediately `out_vld`=0 and `obuf_rdy`=1; the first grant after release searches from index 0.

Source files
------------

// File: rtl/obuf_arb.sv
// Output-port arbiter + FIFO: round-robin grant over IBUF requests, pushes the winner into a small output queue.
// Define OBUF_FIXED_PRIO_EN for fixed lowest-index-first priority (no rotating pointer).
`ifndef PKT_W
`define PKT_W 8
`endif

module obuf_arb #(
    parameter int PYLD_W = `PKT_W,
    parameter int N_IN   = 7,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN-1:0]        arb_req,
    input  logic [N_IN*PYLD_W-1:0] payload_i,
    output logic [N_IN-1:0]        arb_gnt,
    output logic                   obuf_rdy,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [PYLD_W-1:0]      payload_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [PYLD_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
`ifndef OBUF_FIXED_PRIO_EN
    logic [PW-1:0]     r_ptr;
`endif

    logic              w_found;
    logic [PW-1:0]     w_gnt_idx;
    logic [N_IN-1:0]   w_gnt;
    logic              w_push;
    logic              w_pop;
    logic [AW-1:0]     w_wr_nxt;
    logic [AW-1:0]     w_rd_nxt;
    logic [PYLD_W-1:0] w_din;
    int unsigned       w_base;
    int unsigned       w_idx;

    // Search starts at w_base and wraps; first requester found wins.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_gnt     = '0;
        w_idx     = 0;
`ifdef OBUF_FIXED_PRIO_EN
        w_base    = 0;
`else
        w_base    = 32'(r_ptr);
`endif
        for (int unsigned k = 0; k < N_IN; k++) begin
            w_idx = w_base + k;
            if (w_idx >= N_IN)
                w_idx = w_idx - N_IN;
            if (!w_found && arb_req[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = PW'(w_idx);
            end
        end
        if (w_found)
            w_gnt[w_gnt_idx] = 1'b1;
    end

    assign arb_gnt   = w_gnt;
    assign obuf_rdy  = (r_count != CNT_W'(DEPTH));
    assign out_vld   = (r_count != '0);
    assign payload_o = r_mem[r_rd_ptr];

    assign w_push   = w_found && obuf_rdy;
    assign w_pop    = out_vld && out_rdy;
    assign w_din    = payload_i[w_gnt_idx*PYLD_W +: PYLD_W];
    assign w_wr_nxt = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
    assign w_rd_nxt = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_din;
                r_wr_ptr        <= w_wr_nxt;
            end
            if (w_pop)
                r_rd_ptr <= w_rd_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef OBUF_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= '0;
        else if (w_push)
            r_ptr <= (w_gnt_idx == PW'(N_IN - 1)) ? '0 : w_gnt_idx + PW'(1);
    end
`endif

endmodule

// File: tb/tb_obuf_arb.sv
// Scoreboard bench for obuf_arb: directed stimulus pushes expected payloads, a negedge monitor checks pops.
module tb_obuf_arb;

    localparam int PW = 8;
    localparam int NI = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NI-1:0]     arb_req = '0;
    logic [NI*PW-1:0]  payload_i = '0;
    logic [NI-1:0]     arb_gnt;
    logic              obuf_rdy;
    logic              out_vld;
    logic              out_rdy = 1'b0;
    logic [PW-1:0]     payload_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];

    obuf_arb #(.PYLD_W(PW), .N_IN(NI), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .arb_req   (arb_req),
        .payload_i (payload_i),
        .arb_gnt   (arb_gnt),
        .obuf_rdy  (obuf_rdy),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .payload_o (payload_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pl(input int i, input logic [7:0] v);
        payload_i[i*PW +: PW] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // A pop happens at the next rising edge whenever vld&&rdy is seen here.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 32'(payload_o), 32'hFFFF_FFFF);
            end else begin
                check("pop_payload", 32'(payload_o), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [NI-1:0] e_gnt;
        int            idx;

        // Reset
        do_reset();
        #1;
        check("rst_out_vld",  32'(out_vld),   32'd0);
        check("rst_obuf_rdy", 32'(obuf_rdy),  32'd1);
        check("rst_arb_gnt",  32'(arb_gnt),   32'd0);
        check("rst_payload",  32'(payload_o), 32'd0);

        // Single request on input 3
        out_rdy = 1'b1;
        set_pl(3, 8'hA5);
        arb_req = 7'b0001000;
        #1 check("single_gnt", 32'(arb_gnt), 32'h08);
        exp_q.push_back(8'hA5);
        tick();
        arb_req = '0;
        #1;
        check("single_vld", 32'(out_vld),   32'd1);
        check("single_pl",  32'(payload_o), 32'hA5);
        tick();
        check("single_vld_drop", 32'(out_vld), 32'd0);

        // Fairness: all inputs requesting continuously
        do_reset();
        for (int i = 0; i < NI; i++) set_pl(i, 8'(8'h10 + i));
        out_rdy = 1'b1;
        arb_req = 7'h7F;
        for (int k = 0; k < 8; k++) begin
`ifdef OBUF_FIXED_PRIO_EN
            idx = 0;
`else
            idx = k % NI;
`endif
            e_gnt = 7'b1 << idx;
            #1 check("fair_gnt", 32'(arb_gnt), 32'(e_gnt));
            exp_q.push_back(8'(8'h10 + idx));
            tick();
        end
        arb_req = '0;
        tick();
        tick();

        // Backpressure: inputs 1 and 2, downstream stalled
        do_reset();
        out_rdy = 1'b0;
        set_pl(1, 8'h11);
        set_pl(2, 8'h22);
        arb_req = 7'b0000110;
        #1;
        check("bp_gnt1", 32'(arb_gnt),  32'h02);
        check("bp_rdy1", 32'(obuf_rdy), 32'd1);
        exp_q.push_back(8'h11);
        tick();
        arb_req = 7'b0000100;
        #1;
        check("bp_gnt2", 32'(arb_gnt),  32'h04);
        check("bp_rdy2", 32'(obuf_rdy), 32'd1);
        exp_q.push_back(8'h22);
        tick();
        set_pl(1, 8'h33);
        arb_req = 7'b0000010;
        #1;
        check("bp_full_rdy", 32'(obuf_rdy),  32'd0);
        check("bp_full_gnt", 32'(arb_gnt),   32'h02);
        check("bp_head",     32'(payload_o), 32'h11);
        tick();
        check("bp_hold_rdy", 32'(obuf_rdy), 32'd0);
        check("bp_hold_gnt", 32'(arb_gnt),  32'h02);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        #1;
        check("bp_rdy_back", 32'(obuf_rdy),  32'd1);
        check("bp_head2",    32'(payload_o), 32'h22);
        exp_q.push_back(8'h33);
        tick();
        arb_req = '0;
        #1 check("bp_refull", 32'(obuf_rdy), 32'd0);
        out_rdy = 1'b1;
        repeat (3) tick();
        check("bp_drained", 32'(out_vld), 32'd0);

        // Simultaneous push/pop at count=1 (ptr=2 after last grant of input 1)
        out_rdy = 1'b0;
        set_pl(5, 8'h55);
        set_pl(6, 8'h66);
        arb_req = 7'b0100000;
        #1 check("sim_gnt5", 32'(arb_gnt), 32'h20);
        exp_q.push_back(8'h55);
        tick();
        arb_req = 7'b1000000;
        out_rdy = 1'b1;
        #1;
        check("sim_vld1", 32'(out_vld), 32'd1);
        check("sim_gnt6", 32'(arb_gnt), 32'h40);
        exp_q.push_back(8'h66);
        tick();
        arb_req = '0;
        #1;
        check("sim_vld_keep", 32'(out_vld),   32'd1);
        check("sim_rdy_keep", 32'(obuf_rdy),  32'd1);
        check("sim_head",     32'(payload_o), 32'h66);
        tick();
        check("sim_empty", 32'(out_vld), 32'd0);

        // Reset mid-operation with count=2, ptr=5
        out_rdy = 1'b0;
        set_pl(3, 8'h33);
        set_pl(4, 8'h44);
        arb_req = 7'b0001000;
        #1 check("mid_gnt3", 32'(arb_gnt), 32'h08);
        exp_q.push_back(8'h33);
        tick();
        arb_req = 7'b0010000;
        #1 check("mid_gnt4", 32'(arb_gnt), 32'h10);
        exp_q.push_back(8'h44);
        tick();
        arb_req = '0;
        #1 check("mid_full", 32'(obuf_rdy), 32'd0);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_vld", 32'(out_vld),   32'd0);
        check("mid_rst_rdy", 32'(obuf_rdy),  32'd1);
        check("mid_rst_pl",  32'(payload_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_pl(0, 8'h0A);
        set_pl(6, 8'h6A);
        arb_req = 7'b1000001;
        out_rdy = 1'b1;
        #1 check("mid_first_gnt", 32'(arb_gnt), 32'h01);
        exp_q.push_back(8'h0A);
        tick();
        arb_req = '0;
        tick();
        tick();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
